// File: rtl/flash_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : flash_fetch_seq
// Description : Command-driven flash read sequencer. Fetches num_words words
//               starting at base_addr, one outstanding read at a time, and
//               buffers them in a small FIFO drained via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_fetch_seq #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_remaining;

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_start_cmd;
    logic w_push;
    logic w_pop;
    logic w_has_space;

    // A command is accepted only from IDLE; data is accepted only while a read is outstanding.
    assign w_start_cmd = (r_state == c_ST_IDLE) && start;
    assign w_push      = (r_state == c_ST_WAIT) && rd_valid;
    assign w_pop       = out_valid && out_ready;
    assign w_has_space = (r_count < c_FULL_CNT);

    assign rd_addr   = r_addr;
    assign busy      = (r_state != c_ST_IDLE);
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the single-cycle rd_req and done strobes.
    always_comb begin
        w_state_next = r_state;
        rd_req       = 1'b0;
        done         = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = (num_words != '0) ? c_ST_ISSUE : c_ST_DRAIN;
                end
            end
            c_ST_ISSUE: begin
                // Never request a word there is no room to store.
                if (w_has_space) begin
                    rd_req       = 1'b1;
                    w_state_next = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (rd_valid) begin
                    w_state_next = (r_remaining == LEN_W'(1)) ? c_ST_DRAIN : c_ST_ISSUE;
                end
            end
            c_ST_DRAIN: begin
                if (r_count == '0) begin
                    done         = 1'b1;
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Address register and remaining-word counter for the active command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (w_start_cmd) begin
            r_addr      <= base_addr;
            r_remaining <= num_words;
        end else if (w_push) begin
            r_addr      <= r_addr + ADDR_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
        end
    end

    // Output FIFO: circular buffer with occupancy counter; head is read combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= rd_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_fetch_seq
// Description : Directed self-checking bench for flash_fetch_seq. A flash
//               model answers each rd_req three cycles later with
//               data = addr ^ 0xA5A5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_fetch_seq;

    localparam int c_DEPTH   = 4;
    localparam int c_LATENCY = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [9:0]  num_words;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    // Observation log, written only by the main thread.
    logic [15:0] req_addrs [$];
    logic [15:0] got_words [$];
    int          done_cnt;
    int          busy_cnt;
    int          occ;
    bit          outstanding;
    bit          overflow;

    // Stray rd_valid requests: main bumps stray_req, responder bumps stray_ack.
    int stray_req = 0;
    int stray_ack = 0;

    flash_fetch_seq #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .LEN_W      (10),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Flash model: one pending read, answered c_LATENCY cycles after rd_req.
    initial begin
        bit          pend;
        int          cnt;
        logic [15:0] paddr;
        pend     = 1'b0;
        cnt      = 0;
        paddr    = '0;
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rd_req && !pend) begin
                pend  = 1'b1;
                cnt   = c_LATENCY;
                paddr = rd_addr;
            end
            @(posedge clk);
            #1;
            rd_valid = 1'b0;
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = paddr ^ 16'hA5A5;
                    pend     = 1'b0;
                end
            end else if (stray_req != stray_ack) begin
                rd_valid  = 1'b1;
                rd_data   = 16'hDEAD;
                stray_ack = stray_req;
            end
        end
    end

    task automatic clear_log();
        req_addrs.delete();
        got_words.delete();
        done_cnt    = 0;
        busy_cnt    = 0;
        occ         = 0;
        outstanding = 1'b0;
        overflow    = 1'b0;
    endtask

    // Sample one cycle at the falling edge, then return just after the next rising edge.
    task automatic step_cycle();
        bit push;
        bit pop;
        @(negedge clk);
        pop  = out_valid && out_ready;
        push = rd_valid && outstanding;
        if (rd_req) begin
            req_addrs.push_back(rd_addr);
            outstanding = 1'b1;
        end
        if (pop) got_words.push_back(out_data);
        if (push) begin
            if (occ == c_DEPTH && !pop) overflow = 1'b1;
            outstanding = 1'b0;
        end
        occ = occ + int'(push) - int'(pop);
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [15:0] addr, input logic [9:0] n);
        base_addr = addr;
        num_words = n;
        start     = 1'b1;
        step_cycle();
        start     = 1'b0;
    endtask

    task automatic run_until_done(input int max_cycles, input string name);
        int n = 0;
        while (done_cnt == 0 && n < max_cycles) begin
            step_cycle();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, required done pulse", name, n);
        end
        repeat (3) step_cycle();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        out_ready = 1'b0;
        #2;
        checks++; if (rd_req !== 1'b0)     begin failures++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (rd_addr !== 16'h0)   begin failures++; $display("FAIL reset_rd_addr: got %h want 0000", rd_addr); end
        checks++; if (out_data !== 16'h0)  begin failures++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
    endtask

    task automatic test_basic();
        logic [15:0] exp_a [3] = '{16'h0100, 16'h0101, 16'h0102};
        logic [15:0] exp_d [3] = '{16'hA4A5, 16'hA4A4, 16'hA4A7};
        clear_log();
        out_ready = 1'b1;
        issue_cmd(16'h0100, 10'd3);
        run_until_done(200, "basic");
        checks++; if (req_addrs.size() != 3) begin failures++; $display("FAIL basic_req_count: got %0d want 3", req_addrs.size()); end
        checks++; if (got_words.size() != 3) begin failures++; $display("FAIL basic_word_count: got %0d want 3", got_words.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= req_addrs.size() || req_addrs[i] !== exp_a[i]) begin
                failures++; $display("FAIL basic_addr[%0d]: got %h want %h", i, (i < req_addrs.size()) ? req_addrs[i] : 16'hxxxx, exp_a[i]);
            end
            checks++;
            if (i >= got_words.size() || got_words[i] !== exp_d[i]) begin
                failures++; $display("FAIL basic_data[%0d]: got %h want %h", i, (i < got_words.size()) ? got_words[i] : 16'hxxxx, exp_d[i]);
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_d [6] = '{16'hA5B5, 16'hA5B4, 16'hA5B7, 16'hA5B6, 16'hA5B1, 16'hA5B0};
        clear_log();
        out_ready = 1'b0;
        issue_cmd(16'h0010, 10'd6);
        repeat (40) step_cycle();
        checks++; if (req_addrs.size() != 4) begin failures++; $display("FAIL bp_stall_reqs: got %0d want 4", req_addrs.size()); end
        checks++; if (busy !== 1'b1)         begin failures++; $display("FAIL bp_stall_busy: got %b want 1", busy); end
        checks++; if (out_valid !== 1'b1)    begin failures++; $display("FAIL bp_stall_out_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 16'hA5B5) begin failures++; $display("FAIL bp_stall_head: got %h want a5b5", out_data); end
        out_ready = 1'b1;
        run_until_done(300, "bp");
        checks++; if (req_addrs.size() != 6) begin failures++; $display("FAIL bp_total_reqs: got %0d want 6", req_addrs.size()); end
        checks++; if (got_words.size() != 6) begin failures++; $display("FAIL bp_word_count: got %0d want 6", got_words.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= got_words.size() || got_words[i] !== exp_d[i]) begin
                failures++; $display("FAIL bp_data[%0d]: got %h want %h", i, (i < got_words.size()) ? got_words[i] : 16'hxxxx, exp_d[i]);
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
        checks++; if (overflow)      begin failures++; $display("FAIL bp_overflow: push into full FIFO seen, want none"); end
    endtask

    task automatic test_zero_len();
        clear_log();
        out_ready = 1'b1;
        issue_cmd(16'h1234, 10'd0);
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL zero_done_in_start_cycle: got %0d want 0", done_cnt); end
        step_cycle();
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_next_cycle: got %0d want 1", done_cnt); end
        repeat (3) step_cycle();
        checks++; if (done_cnt != 1)         begin failures++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
        checks++; if (busy_cnt != 1)         begin failures++; $display("FAIL zero_busy_cycles: got %0d want 1", busy_cnt); end
        checks++; if (req_addrs.size() != 0) begin failures++; $display("FAIL zero_reqs: got %0d want 0", req_addrs.size()); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_a [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        logic [15:0] exp_d [4] = '{16'h5A5B, 16'h5A5A, 16'hA5A5, 16'hA5A4};
        clear_log();
        out_ready = 1'b1;
        issue_cmd(16'hFFFE, 10'd4);
        run_until_done(200, "wrap");
        checks++; if (req_addrs.size() != 4) begin failures++; $display("FAIL wrap_req_count: got %0d want 4", req_addrs.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= req_addrs.size() || req_addrs[i] !== exp_a[i]) begin
                failures++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, (i < req_addrs.size()) ? req_addrs[i] : 16'hxxxx, exp_a[i]);
            end
            checks++;
            if (i >= got_words.size() || got_words[i] !== exp_d[i]) begin
                failures++; $display("FAIL wrap_data[%0d]: got %h want %h", i, (i < got_words.size()) ? got_words[i] : 16'hxxxx, exp_d[i]);
            end
        end
    endtask

    task automatic test_noise();
        logic [15:0] exp_d [6] = '{16'hA1A5, 16'hA1A4, 16'hA1A7, 16'hA1A6, 16'hA1A1, 16'hA1A0};
        clear_log();
        out_ready = 1'b0;
        issue_cmd(16'h0400, 10'd6);
        repeat (30) step_cycle();
        // Second start while busy, then a stray rd_valid while stalled in ISSUE.
        issue_cmd(16'h7777, 10'd5);
        stray_req++;
        repeat (5) step_cycle();
        checks++; if (req_addrs.size() != 4) begin failures++; $display("FAIL noise_stall_reqs: got %0d want 4", req_addrs.size()); end
        out_ready = 1'b1;
        run_until_done(300, "noise");
        repeat (10) step_cycle();
        checks++; if (got_words.size() != 6) begin failures++; $display("FAIL noise_word_count: got %0d want 6", got_words.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= got_words.size() || got_words[i] !== exp_d[i]) begin
                failures++; $display("FAIL noise_data[%0d]: got %h want %h", i, (i < got_words.size()) ? got_words[i] : 16'hxxxx, exp_d[i]);
            end
        end
        checks++; if (req_addrs.size() != 6) begin failures++; $display("FAIL noise_total_reqs: got %0d want 6", req_addrs.size()); end
        checks++; if (done_cnt != 1)         begin failures++; $display("FAIL noise_done_count: got %0d want 1", done_cnt); end
        checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL noise_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        logic [15:0] exp_d [2] = '{16'hA6A5, 16'hA6A4};
        clear_log();
        out_ready = 1'b0;
        issue_cmd(16'h0200, 10'd4);
        while (req_addrs.size() < 3 && n < 100) begin
            step_cycle();
            n++;
        end
        checks++; if (req_addrs.size() < 3) begin failures++; $display("FAIL midrst_third_req: got %0d reqs want 3", req_addrs.size()); end
        checks++; if (out_valid !== 1'b1)   begin failures++; $display("FAIL midrst_pre_out_valid: got %b want 1", out_valid); end
        // Now in WAIT with two words buffered and the third read outstanding.
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (rd_req !== 1'b0)    begin failures++; $display("FAIL midrst_rd_req: got %b want 0", rd_req); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        out_ready = 1'b1;
        repeat (8) step_cycle();
        checks++; if (got_words.size() != 0) begin failures++; $display("FAIL midrst_late_valid_words: got %0d want 0", got_words.size()); end
        checks++; if (busy_cnt != 0)         begin failures++; $display("FAIL midrst_idle_busy: got %0d want 0", busy_cnt); end
        clear_log();
        issue_cmd(16'h0300, 10'd2);
        run_until_done(200, "midrst_new");
        checks++; if (got_words.size() != 2) begin failures++; $display("FAIL midrst_new_count: got %0d want 2", got_words.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= got_words.size() || got_words[i] !== exp_d[i]) begin
                failures++; $display("FAIL midrst_new_data[%0d]: got %h want %h", i, (i < got_words.size()) ? got_words[i] : 16'hxxxx, exp_d[i]);
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL midrst_new_done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_wrap();
        test_noise();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flash_fetch_seq.md
Name: flash_fetch_seq

Overview:
- Command-driven read sequencer that sits directly upstream of the flash memory controller in the digit-recognizer datapath.
- Given a base address and word count, it issues one flash read at a time and captures each returned word into a small FIFO.
- Downstream (weight/pixel consumers) pulls words from the FIFO with a valid/ready handshake.
- Throttles itself so it never issues a read it has no FIFO space to store.

Parameters:
- ADDR_W, 16, flash address width
- DATA_W, 16, flash data word width
- LEN_W, 10, width of the word-count field (max 1023 words per command)
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first flash address of the command
- num_words  in  LEN_W  words to fetch
- rd_req  out  1  one-cycle read request to the flash controller
- rd_addr  out  ADDR_W  read address; stable from the rd_req cycle until rd_valid
- rd_valid  in  1  one-cycle strobe: rd_data holds the requested word
- rd_data  in  DATA_W  returned flash word
- out_data  out  DATA_W  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the head word when out_valid is also high
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a command has fully completed

Behaviour:
- Reset:
  - State goes to IDLE.
  - rd_req, busy, done and out_valid are 0.
  - rd_addr, out_data and the remaining count are 0.
  - FIFO is flushed.
  - Reset asserted mid-command abandons the command; a late rd_valid after reset is ignored.
- IDLE:
  - On start, latch base_addr into the address register and num_words into the remaining counter.
  - If num_words is nonzero, go to ISSUE. If num_words is 0, go to DRAIN (this produces done with no reads).
  - start while busy is ignored and not queued.
- ISSUE:
  - If FIFO occupancy is below FIFO_DEPTH, assert rd_req for exactly one cycle with rd_addr equal to the address register, then go to WAIT.
  - Otherwise stay in ISSUE with rd_req low.
- WAIT:
  - rd_req is low and rd_addr is held.
  - On rd_valid: push rd_data into the FIFO, increment the address register modulo 2^ADDR_W (0xFFFF wraps to 0x0000), and decrement the remaining counter.
  - If the remaining count was 1, go to DRAIN; otherwise go to ISSUE.
  - Exactly one read is outstanding at a time, so minimum spacing between rd_req pulses is 2 cycles (req, valid).
- DRAIN:
  - Wait until the FIFO is empty.
  - In the cycle it is observed empty, pulse done for one cycle and go to IDLE; busy drops in the same cycle that state returns to IDLE.
  - For num_words=0: done pulses in the cycle after start.
- rd_valid outside WAIT is ignored (no push).
- FIFO:
  - Synchronous circular buffer with an occupancy counter of log2(FIFO_DEPTH)+1 bits.
  - Push happens on an accepted rd_valid; pop happens when out_valid and out_ready are both high.
  - Simultaneous push and pop leaves the count unchanged and preserves data order.
  - out_data is the head entry, fed combinationally from the storage array.
  - FIFO depth throttling makes a push into a full FIFO impossible. The bench asserts that it never occurs.
  - Pop while empty is ignored.
- out_ready may be held low indefinitely; the sequencer then stalls in ISSUE with no lost or duplicated words.

Test Plan:
- Basic fetch: start, base_addr=0x0100, num_words=3, rd_valid 3 cycles after each rd_req with data=addr^0xA5A5, out_ready=1 -> rd_addr 0x0100/0x0101/0x0102, out_data 0xA4A5/0xA4A4/0xA4A7 in order, one done pulse, busy low afterwards.
- Backpressure: num_words=6, out_ready=0 -> exactly 4 rd_req pulses, then stall in ISSUE; raise out_ready -> remaining 2 reads issue, 6 words out in order, done.
- Zero length: start with num_words=0 -> no rd_req, done high in the cycle after start, busy high for exactly 1 cycle.
- Address wrap: base_addr=0xFFFE, num_words=4 -> rd_addr 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Protocol noise: pulse start again mid-command and inject a stray rd_valid in ISSUE -> command unaffected, no extra FIFO entry, single done.
- Mid-command reset: assert rst while in WAIT with 2 words in the FIFO -> out_valid, busy and rd_req are 0 immediately; a subsequent rd_valid is ignored; a new command runs correctly.
